// File: rtl/uart_tx_wb.sv
// Wishbone-fed 8N1 UART transmitter; one byte per accepted request, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_wb #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic [7:0] dat_i,
  output logic       stall_o,
  output logic       ack_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_q;
  logic             req;
  logic             accept;
  logic             baud_done;
  logic             tx_d;

  assign req       = cyc_i && stb_i;
  assign baud_done = (baud_cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; requests are only taken while idle
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        if (baud_done) begin
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs; tx_d is the line level for the upcoming state so tx_o lands on the transition edge
  always_comb begin
    busy_o  = (state != IDLE);
    stall_o = req && (state != IDLE);
    tx_d    = 1'b1;
    case (state_next)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_q[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = ^shift_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath: baud timing, bit index, latched byte, registered line and ack
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift_q  <= 8'h00;
      tx_o     <= 1'b1;
      ack_o    <= 1'b0;
    end else begin
      ack_o   <= accept;
      tx_o    <= tx_d;
      bit_idx <= bit_idx_next;
      if (accept) shift_q <= dat_i;
      if ((state == IDLE) || (state_next != state) || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_wb.sv
// Bench for uart_tx_wb: directed and random bytes checked cycle-by-cycle against a bit-list frame model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_wb;

  localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cyc_i;
  logic       stb_i;
  logic [7:0] dat_i;
  logic       stall_o;
  logic       ack_o;
  logic       tx_o;
  logic       busy_o;

  int tests    = 0;
  int fails    = 0;
  int ack_cnt  = 0;
  logic prev_ack = 1'b0;

  uart_tx_wb #(.CLKS_PER_BIT(C)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .dat_i   (dat_i),
    .stall_o (stall_o),
    .ack_o   (ack_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle to the next falling edge and apply the always-true properties
  task automatic step();
    @(negedge clk);
    if (ack_o === 1'b1) ack_cnt++;
    tests++;
    assert (!(ack_o === 1'b1 && prev_ack === 1'b1)) else begin
      fails++;
      $error("FAIL ack_twice: observed ack=%b prev=%b expected no back-to-back ack", ack_o, prev_ack);
    end
    prev_ack = ack_o;
    if (busy_o === 1'b0) chk("tx_idle_high", 32'(tx_o), 32'd1);
  endtask

  // Expected line level for the k-th bit period of a frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic bits[$];
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    return bits[k];
  endfunction

  // Entered at the falling edge just after the accepting edge; leaves one cycle past frame end
  task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_dat);
    for (int i = 0; i < int'(NBITS * C); i++) begin
      chk("tx_bit", 32'(tx_o), 32'(frame_bit(b, i / int'(C))));
      chk("busy", 32'(busy_o), 32'd1);
      chk("ack", 32'(ack_o), (i == 0) ? 32'd1 : 32'd0);
      chk("stall", 32'(stall_o), (i == 0 || hold) ? 32'd1 : 32'd0);
      if (i == 0) begin
        if (!hold) begin
          cyc_i = 1'b0;
          stb_i = 1'b0;
          dat_i = 8'($urandom);
        end else begin
          dat_i = next_dat;
        end
      end
      step();
    end
    chk("end_busy", 32'(busy_o), 32'd0);
    chk("end_tx", 32'(tx_o), 32'd1);
    chk("end_ack", 32'(ack_o), 32'd0);
    chk("end_stall", 32'(stall_o), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    dat_i = b;
    step();
    run_frame(b, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int acks0;
    rst_ni = 1'b0;
    cyc_i  = 1'b0;
    stb_i  = 1'b0;
    dat_i  = 8'h00;
    step();
    step();
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_ni = 1'b1;
    step();

    // Directed bytes, including the parity reference values
    send(8'hA5);
    send(8'h07);
    send(8'h03);

    // Strobe without cycle is not a request
    stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dat_i = 8'($urandom);
      step();
      chk("nocyc_ack", 32'(ack_o), 32'd0);
      chk("nocyc_tx", 32'(tx_o), 32'd1);
      chk("nocyc_stall", 32'(stall_o), 32'd0);
      chk("nocyc_busy", 32'(busy_o), 32'd0);
    end
    stb_i = 1'b0;

    // Request held through a frame: stalled, then taken in the single idle cycle
    acks0 = ack_cnt;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    dat_i = 8'h3C;
    step();
    run_frame(8'h3C, 1'b1, 8'hC3);
    step();
    run_frame(8'hC3, 1'b0, 8'h00);
    chk("b2b_acks", 32'(ack_cnt - acks0), 32'd2);

    // Reset in the middle of data bit 3 aborts the frame
    cyc_i = 1'b1;
    stb_i = 1'b1;
    dat_i = 8'hFF;
    step();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    for (int i = 0; i < int'(4 * C + 1); i++) step();
    chk("mid_busy", 32'(busy_o), 32'd1);
    chk("mid_tx", 32'(tx_o), 32'd1);
    rst_ni = 1'b0;
    step();
    chk("abort_tx", 32'(tx_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_ack", 32'(ack_o), 32'd0);
    rst_ni = 1'b1;
    step();
    send(8'h00);

    // Request presented during reset is not taken; it is taken once reset lifts
    rst_ni = 1'b0;
    cyc_i  = 1'b1;
    stb_i  = 1'b1;
    dat_i  = 8'h5A;
    step();
    chk("rstreq_ack", 32'(ack_o), 32'd0);
    chk("rstreq_busy", 32'(busy_o), 32'd0);
    chk("rstreq_tx", 32'(tx_o), 32'd1);
    rst_ni = 1'b1;
    step();
    run_frame(8'h5A, 1'b0, 8'h00);

    // Random bytes with random idle gaps
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      send(b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
